// File: rtl/card_dealer_if.sv
// Draw interface between the game FSM (master) and the card dealer (slave).
// The master requests cards with single-cycle pip pulses and may ask for a
// fresh deck with reshuffle; the slave answers with the drawn card value
// and its status flags.
interface card_dealer_if;
   logic       reshuffle;
   logic       pip;
   logic [3:0] number;
   logic       num_valid;
   logic       empty;
   logic       ready;
   logic [5:0] cards_left;

   modport master (
      output reshuffle,
      output pip,
      input  number,
      input  num_valid,
      input  empty,
      input  ready,
      input  cards_left
   );

   modport slave (
      input  reshuffle,
      input  pip,
      output number,
      output num_valid,
      output empty,
      output ready,
      output cards_left
   );
endinterface

// File: rtl/card_dealer.sv
// Card source for the tenthirty game.
// Builds a deck of DECK_SIZE cards (value of index i is (i % 13) + 1), then
// optionally shuffles it in place with a Fisher-Yates pass whose random index
// comes from a free-running 16-bit Fibonacci LFSR.  Out-of-range candidates
// are rejected and retried on the next cycle rather than reduced modulo i,
// which keeps the shuffle free of modulo bias.  Each accepted pip returns one
// card one cycle later; empty rises together with the last card.
module card_dealer #(
   parameter int unsigned DECK_SIZE  = 52,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1,
   parameter bit          SHUFFLE_EN = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   card_dealer_if.slave bus
);

   localparam logic [5:0] DECK_FULL  = 6'(DECK_SIZE);
   localparam logic [5:0] DECK_LAST  = 6'(DECK_SIZE - 1);
   // A one-card deck has nothing to swap; skip the shuffle so it cannot stall
   localparam bit         DO_SHUFFLE = SHUFFLE_EN && (DECK_SIZE > 1);

   typedef enum logic [1:0] {
      ST_BUILD   = 2'd0,
      ST_SHUFFLE = 2'd1,
      ST_READY   = 2'd2
   } state_t;

   // Registered state
   state_t      state_q;
   logic [15:0] lfsr_q;
   logic [3:0]  deck_q [DECK_SIZE];
   logic [5:0]  idx_q;          // build index k, then shuffle index i
   logic [3:0]  val_q;          // value written at deck[k]; tracks (k % 13) + 1
   logic [5:0]  ptr_q;          // next card to draw
   logic [5:0]  cards_left_q;
   logic [3:0]  number_q;
   logic        num_valid_q;
   logic        empty_q;
   logic        ready_q;

   // Next-state and combinational helpers
   logic [15:0] lfsr_d;
   logic        lfsr_fb_s;
   logic [3:0]  val_d;
   logic [5:0]  cand_s;
   logic        accept_s;
   logic [5:0]  swap_j_s;
   logic [3:0]  card_i_s;
   logic [3:0]  card_j_s;
   logic [5:0]  ptr_inc_s;
   logic [5:0]  ptr_rd_s;
   logic [3:0]  card_ptr_s;

   // Fibonacci LFSR step with taps 16,14,13,11
   always_comb begin
      lfsr_fb_s = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
      lfsr_d    = {lfsr_q[14:0], lfsr_fb_s};
   end

   // Shuffle candidate and the two deck entries taking part in a swap
   always_comb begin
      cand_s   = lfsr_q[5:0];
      accept_s = (cand_s <= idx_q);
      if (accept_s) begin
         swap_j_s = cand_s;
      end else begin
         swap_j_s = idx_q;      // keeps the read index inside the deck on reject
      end
      card_i_s = deck_q[idx_q];
      card_j_s = deck_q[swap_j_s];
   end

   // Build value sequence 1..13 and the card under the draw pointer
   always_comb begin
      if (val_q == 4'd13) begin
         val_d = 4'd1;
      end else begin
         val_d = val_q + 4'd1;
      end
      ptr_inc_s = ptr_q + 6'd1;
      if (ptr_q < DECK_FULL) begin
         ptr_rd_s = ptr_q;
      end else begin
         ptr_rd_s = 6'd0;       // deck exhausted; read is never used
      end
      card_ptr_s = deck_q[ptr_rd_s];
   end

   // Main FSM: build, shuffle, serve draws; reshuffle restarts from build
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_BUILD;
         lfsr_q       <= LFSR_SEED;
         idx_q        <= 6'd0;
         val_q        <= 4'd1;
         ptr_q        <= 6'd0;
         cards_left_q <= DECK_FULL;
         number_q     <= 4'd0;
         num_valid_q  <= 1'b0;
         empty_q      <= 1'b0;
         ready_q      <= 1'b0;
      end else begin
         lfsr_q      <= lfsr_d;
         num_valid_q <= 1'b0;
         if (bus.reshuffle) begin
            // Overrides any pip in the same cycle; number keeps its value
            state_q      <= ST_BUILD;
            idx_q        <= 6'd0;
            val_q        <= 4'd1;
            ptr_q        <= 6'd0;
            cards_left_q <= DECK_FULL;
            empty_q      <= 1'b0;
            ready_q      <= 1'b0;
         end else begin
            case (state_q)
               ST_BUILD: begin
                  deck_q[idx_q] <= val_q;
                  val_q         <= val_d;
                  if (idx_q == DECK_LAST) begin
                     // idx_q stays at DECK_SIZE-1: the first shuffle index
                     if (DO_SHUFFLE) begin
                        state_q <= ST_SHUFFLE;
                     end else begin
                        state_q <= ST_READY;
                        ready_q <= 1'b1;
                     end
                  end else begin
                     idx_q <= idx_q + 6'd1;
                  end
               end
               ST_SHUFFLE: begin
                  if (accept_s) begin
                     deck_q[idx_q]    <= card_j_s;
                     deck_q[swap_j_s] <= card_i_s;
                     if (idx_q == 6'd1) begin
                        state_q <= ST_READY;
                        ready_q <= 1'b1;
                     end else begin
                        idx_q <= idx_q - 6'd1;
                     end
                  end else begin
                     idx_q <= idx_q;    // rejected candidate: retry next cycle
                  end
               end
               ST_READY: begin
                  if (bus.pip && !empty_q) begin
                     number_q     <= card_ptr_s;
                     num_valid_q  <= 1'b1;
                     ptr_q        <= ptr_inc_s;
                     cards_left_q <= DECK_FULL - ptr_inc_s;
                     empty_q      <= (ptr_inc_s == DECK_FULL);
                  end else begin
                     ptr_q <= ptr_q;    // idle, or pip against an empty deck
                  end
               end
               default: begin
                  state_q <= ST_BUILD;
                  idx_q   <= 6'd0;
                  val_q   <= 4'd1;
                  ready_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.number     = number_q;
   assign bus.num_valid  = num_valid_q;
   assign bus.empty      = empty_q;
   assign bus.ready      = ready_q;
   assign bus.cards_left = cards_left_q;

endmodule

// File: tb/tb_card_dealer.sv
// Bench for card_dealer: one unshuffled and one shuffled instance share the
// same clock, reset and stimulus.  A deck-level reference model predicts
// every output of both instances each cycle; directed tables and sequences
// cover the draw, exhaustion, reshuffle and reset corner cases.
module tb_card_dealer;

   localparam logic [15:0] SEED = 16'hACE1;
   localparam int          N    = 52;

   logic clk = 1'b0;
   logic rst;
   logic pip;
   logic reshuffle;

   card_dealer_if if0 ();
   card_dealer_if if1 ();

   assign if0.pip       = pip;
   assign if0.reshuffle = reshuffle;
   assign if1.pip       = pip;
   assign if1.reshuffle = reshuffle;

   card_dealer #(.DECK_SIZE(N), .LFSR_SEED(SEED), .SHUFFLE_EN(1'b0)) u_dut0 (
      .clk (clk),
      .rst (rst),
      .bus (if0)
   );

   card_dealer #(.DECK_SIZE(N), .LFSR_SEED(SEED), .SHUFFLE_EN(1'b1)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (if1)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   // Reference model state, per instance
   logic [15:0] m_lfsr;
   int          m_deck [2][N];
   int          m_busy [2];      // cycles until ready
   int          m_drawn[2];
   int          m_num  [2];
   bit          m_nv   [2];

   int q0[$];
   int q1[$];
   int seq1[$];

   typedef struct {
      bit pip;
      bit exp_nv;
      int exp_num;
      int exp_left;
   } vec_t;
   vec_t tbl[16];

   task automatic check(string name, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   function automatic logic [15:0] lfsr_next(logic [15:0] l);
      logic fb;
      fb = l[15] ^ l[13] ^ l[12] ^ l[10];
      return {l[14:0], fb};
   endfunction

   // Build the deck, shuffle it the way the dealer does, and count cycles to ready
   task automatic model_build(int inst, logic [15:0] l0);
      logic [15:0] l;
      int i;
      int j;
      int t;
      for (int k = 0; k < N; k++) m_deck[inst][k] = (k % 13) + 1;
      l = l0;
      for (int k = 0; k < N; k++) l = lfsr_next(l);
      m_busy[inst] = N;
      if (inst == 1) begin
         i = N - 1;
         while (i >= 1) begin
            j = int'(l[5:0]);
            if (j <= i) begin
               t = m_deck[inst][i];
               m_deck[inst][i] = m_deck[inst][j];
               m_deck[inst][j] = t;
               i--;
            end
            l = lfsr_next(l);
            m_busy[inst]++;
         end
      end
   endtask

   task automatic model_step(bit r, bit p, bit s);
      logic [15:0] nxt;
      if (r) begin
         m_lfsr = SEED;
         for (int n = 0; n < 2; n++) begin
            model_build(n, SEED);
            m_drawn[n] = 0;
            m_num[n]   = 0;
            m_nv[n]    = 1'b0;
         end
      end else begin
         nxt = lfsr_next(m_lfsr);
         for (int n = 0; n < 2; n++) begin
            m_nv[n] = 1'b0;
            if (s) begin
               model_build(n, nxt);
               m_drawn[n] = 0;
            end else if (m_busy[n] > 0) begin
               m_busy[n]--;
            end else if (p && m_drawn[n] < N) begin
               m_num[n] = m_deck[n][m_drawn[n]];
               m_drawn[n]++;
               m_nv[n] = 1'b1;
            end
         end
         m_lfsr = nxt;
      end
   endtask

   task automatic compare_all();
      check("m0_num_valid",  int'(if0.num_valid),  int'(m_nv[0]));
      check("m0_number",     int'(if0.number),     m_num[0]);
      check("m0_ready",      int'(if0.ready),      int'(m_busy[0] == 0));
      check("m0_empty",      int'(if0.empty),      int'(m_drawn[0] == N));
      check("m0_cards_left", int'(if0.cards_left), N - m_drawn[0]);
      check("m1_num_valid",  int'(if1.num_valid),  int'(m_nv[1]));
      check("m1_number",     int'(if1.number),     m_num[1]);
      check("m1_ready",      int'(if1.ready),      int'(m_busy[1] == 0));
      check("m1_empty",      int'(if1.empty),      int'(m_drawn[1] == N));
      check("m1_cards_left", int'(if1.cards_left), N - m_drawn[1]);
   endtask

   // One clock: inputs sampled at posedge, model advanced and compared at negedge
   task automatic tick();
      bit r;
      bit p;
      bit s;
      @(posedge clk);
      r = rst;
      p = pip;
      s = reshuffle;
      @(negedge clk);
      model_step(r, p, s);
      if (chk_en) compare_all();
   endtask

   task automatic wait_ready(int inst, int bound, string name);
      int n;
      n = 0;
      while (((inst == 0) ? if0.ready : if1.ready) !== 1'b1 && n < bound) begin
         tick();
         n++;
      end
      check(name, int'((inst == 0) ? if0.ready : if1.ready), 1);
   endtask

   task automatic draw(int n);
      for (int k = 0; k < n; k++) begin
         pip = 1'b1;
         tick();
         if (if0.num_valid) q0.push_back(int'(if0.number));
         if (if1.num_valid) q1.push_back(int'(if1.number));
      end
      pip = 1'b0;
   endtask

   task automatic check_reset_outputs(string tag);
      check({tag, "_d0_number"}, int'(if0.number), 0);
      check({tag, "_d0_valid"},  int'(if0.num_valid), 0);
      check({tag, "_d0_ready"},  int'(if0.ready), 0);
      check({tag, "_d1_number"}, int'(if1.number), 0);
      check({tag, "_d1_valid"},  int'(if1.num_valid), 0);
      check({tag, "_d1_ready"},  int'(if1.ready), 0);
      check({tag, "_d1_empty"},  int'(if1.empty), 0);
      check({tag, "_d1_left"},   int'(if1.cards_left), N);
   endtask

   task automatic check_hist(string tag);
      int cnt[14];
      for (int v = 0; v < 14; v++) cnt[v] = 0;
      check({tag, "_size"}, q1.size(), N);
      foreach (q1[k]) begin
         if (q1[k] >= 1 && q1[k] <= 13) cnt[q1[k]]++;
      end
      for (int v = 1; v <= 13; v++) check($sformatf("%s_count_%0d", tag, v), cnt[v], 4);
   endtask

   initial begin
      int diff;
      tbl[0]  = '{1'b1, 1'b1,  1, 51};
      tbl[1]  = '{1'b1, 1'b1,  2, 50};
      tbl[2]  = '{1'b1, 1'b1,  3, 49};
      tbl[3]  = '{1'b0, 1'b0,  3, 49};
      tbl[4]  = '{1'b1, 1'b1,  4, 48};
      tbl[5]  = '{1'b1, 1'b1,  5, 47};
      tbl[6]  = '{1'b0, 1'b0,  5, 47};
      tbl[7]  = '{1'b0, 1'b0,  5, 47};
      tbl[8]  = '{1'b1, 1'b1,  6, 46};
      tbl[9]  = '{1'b1, 1'b1,  7, 45};
      tbl[10] = '{1'b1, 1'b1,  8, 44};
      tbl[11] = '{1'b1, 1'b1,  9, 43};
      tbl[12] = '{1'b1, 1'b1, 10, 42};
      tbl[13] = '{1'b1, 1'b1, 11, 41};
      tbl[14] = '{1'b1, 1'b1, 12, 40};
      tbl[15] = '{1'b1, 1'b1, 13, 39};

      rst = 1'b1;
      pip = 1'b0;
      reshuffle = 1'b0;
      tick();
      tick();
      chk_en = 1'b1;
      check_reset_outputs("reset");
      check("reset_d0_left", int'(if0.cards_left), N);
      rst = 1'b0;

      // Unshuffled deck comes out in build order, one cycle after each pip
      wait_ready(0, 100, "d0_ready_wait");
      for (int e = 0; e < 16; e++) begin
         pip = tbl[e].pip;
         tick();
         check($sformatf("tbl%0d_valid", e), int'(if0.num_valid), int'(tbl[e].exp_nv));
         check($sformatf("tbl%0d_number", e), int'(if0.number), tbl[e].exp_num);
         check($sformatf("tbl%0d_left", e), int'(if0.cards_left), tbl[e].exp_left);
         check($sformatf("tbl%0d_empty", e), int'(if0.empty), 0);
         // the shuffled instance is still shuffling: pips are dropped
         check($sformatf("tbl%0d_d1_valid", e), int'(if1.num_valid), 0);
         check($sformatf("tbl%0d_d1_left", e), int'(if1.cards_left), N);
      end
      pip = 1'b0;

      // Drain both decks
      wait_ready(1, 2000, "d1_ready_wait");
      q0.delete();
      q1.delete();
      draw(39);
      check("d0_drain_pulses", q0.size(), 39);
      check("d0_last_valid", int'(if0.num_valid), 1);
      check("d0_last_empty", int'(if0.empty), 1);
      check("d0_last_left", int'(if0.cards_left), 0);
      check("d0_last_number", int'(if0.number), 13);
      check("d1_first_card", (q1.size() > 0) ? q1[0] : -1, m_deck[1][0]);
      draw(13);
      check("d0_extra_pulses", q0.size(), 39);
      check("d0_number_held", int'(if0.number), 13);
      check("d1_empty", int'(if1.empty), 1);
      check_hist("run1");
      diff = 0;
      foreach (q1[k]) if (q1[k] != (k % 13) + 1) diff++;
      check("run1_not_build_order", int'(diff > 0), 1);
      seq1 = q1;

      // Reset mid-shuffle and mid-draw, then the sequence must repeat
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (80) tick();
      check("mid_shuffle_busy", int'(if1.ready), 0);
      rst = 1'b1;
      tick();
      check_reset_outputs("rst_shuffle");
      rst = 1'b0;
      wait_ready(1, 2000, "d1_ready_wait2");
      draw(10);
      rst = 1'b1;
      pip = 1'b1;
      tick();
      check_reset_outputs("rst_draw");
      rst = 1'b0;
      pip = 1'b0;
      wait_ready(1, 2000, "d1_ready_wait3");
      q1.delete();
      draw(N);
      check("repeat_size", q1.size(), N);
      diff = 0;
      foreach (seq1[k]) if (k >= q1.size() || q1[k] != seq1[k]) diff++;
      check("repeat_sequence_diffs", diff, 0);

      // Reshuffle after 20 draws, colliding with a pip
      rst = 1'b1;
      tick();
      rst = 1'b0;
      wait_ready(1, 2000, "d1_ready_wait4");
      draw(20);
      check("pre_reshuffle_left", int'(if1.cards_left), N - 20);
      reshuffle = 1'b1;
      pip = 1'b1;
      tick();
      reshuffle = 1'b0;
      pip = 1'b0;
      check("resh_d1_valid", int'(if1.num_valid), 0);
      check("resh_d0_valid", int'(if0.num_valid), 0);
      check("resh_d1_ready", int'(if1.ready), 0);
      check("resh_d1_left", int'(if1.cards_left), N);
      check("resh_d1_empty", int'(if1.empty), 0);
      wait_ready(1, 2000, "d1_ready_wait5");
      q1.delete();
      draw(N);
      check_hist("run2");
      diff = 0;
      foreach (seq1[k]) if (k >= q1.size() || q1[k] != seq1[k]) diff++;
      check("reshuffle_new_order", int'(diff > 0), 1);

      // Random traffic against the model
      for (int c = 0; c < 2500; c++) begin
         pip       = 1'($urandom_range(0, 1));
         reshuffle = ($urandom_range(0, 299) == 0);
         rst       = ($urandom_range(0, 999) == 0);
         tick();
      end
      rst = 1'b0;
      pip = 1'b0;
      reshuffle = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
